// File: rtl/cla_sub_pipe_32_if.sv
// Operand/result handshake bundle for cla_sub_pipe_32.
// The master side issues operands and consumes results. The slave side is the subtractor.
interface cla_sub_pipe_32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/cla_sub_pipe_32.sv
// Two-stage pipelined CLA subtractor: diff = a + ~b + 1, low half in S1, high half in S2.
// Define SUB_STATUS_FLAGS_EN to build the ovf/zero status registers; otherwise they read 0.
module cla_sub_pipe_32 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_sub_pipe_32_if.slave   bus
);
    // The half width must be a multiple of 4 so that it splits into whole CLA groups.
    localparam int HALF = WIDTH / 2;

    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x, input logic [HALF-1:0] y,
                                               input logic cin);
        logic [HALF-1:0] s;
        logic [4:0]      r;
        logic            c;
        s = '0;
        c = cin;
        for (int i = 0; i < HALF / 4; i++) begin
            r          = cla4(x[4*i +: 4], y[4*i +: 4], c);
            s[4*i +: 4] = r[3:0];
            c          = r[4];
        end
        return {c, s};
    endfunction

    logic            vld_p1, vld_p2;
    logic            in_fire, out_fire, s2_adv;
    logic [HALF-1:0] ah_p1, nbh_p1, lo_p1;
    logic            c_mid_p1;
    logic [HALF:0]   lo_sum, hi_sum;
    logic signed [WIDTH-1:0] diff_nxt;
    logic [WIDTH-1:0] diff_p2;
    logic            borrow_p2;

    assign s2_adv      = vld_p1 && (!vld_p2 || bus.out_ready);
    assign bus.in_ready = !vld_p1 || s2_adv;
    assign in_fire     = bus.in_valid && bus.in_ready;
    assign out_fire    = vld_p2 && bus.out_ready;

    assign lo_sum   = cla_half(bus.a[HALF-1:0], ~bus.b[HALF-1:0], 1'b1);
    assign hi_sum   = cla_half(ah_p1, nbh_p1, c_mid_p1);
    assign diff_nxt = {hi_sum[HALF-1:0], lo_p1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_fire)     vld_p1 <= 1'b1;
            else if (s2_adv) vld_p1 <= 1'b0;
            if (s2_adv)        vld_p2 <= 1'b1;
            else if (out_fire) vld_p2 <= 1'b0;
        end
    end

    // ---- stage 1: low-half sum and the high-half operands ----
    always_ff @(posedge clk) begin
        if (in_fire) begin
            ah_p1    <= bus.a[WIDTH-1:HALF];
            nbh_p1   <= ~bus.b[WIDTH-1:HALF];
            lo_p1    <= lo_sum[HALF-1:0];
            c_mid_p1 <= lo_sum[HALF];
        end
    end

    // ---- stage 2: high-half sum and the result registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_p2   <= '0;
            borrow_p2 <= 1'b0;
        end else if (s2_adv) begin
            diff_p2   <= diff_nxt;
            borrow_p2 <= ~hi_sum[HALF];
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.diff      = diff_p2;
    assign bus.borrow    = borrow_p2;

`ifdef SUB_STATUS_FLAGS_EN
    logic ovf_p2, zero_p2;

    // Matching sign bits of a and ~b mean that a and b have opposite signs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p2  <= 1'b0;
            zero_p2 <= 1'b0;
        end else if (s2_adv) begin
            ovf_p2  <= (ah_p1[HALF-1] == nbh_p1[HALF-1]) && (diff_nxt[WIDTH-1] != ah_p1[HALF-1]);
            zero_p2 <= ~|diff_nxt;
        end
    end

    assign bus.ovf  = ovf_p2;
    assign bus.zero = zero_p2;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif
endmodule

// File: tb/tb_cla_sub_pipe_32.sv
// Directed-vector bench for cla_sub_pipe_32; the ovf/zero expectations follow SUB_STATUS_FLAGS_EN.
module tb_cla_sub_pipe_32;
`ifdef SUB_STATUS_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    cla_sub_pipe_32_if #(.WIDTH(32)) bus ();

    cla_sub_pipe_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Send one pair with out_ready high. Report the output after the first edge and after the second edge.
    task automatic run_one(input logic [31:0] av, input logic [31:0] bv, output logic early_vld,
                           output logic vld, output logic [31:0] d, output logic br,
                           output logic ov, output logic zr);
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        early_vld    = bus.out_valid;
        @(posedge clk); #1;
        vld = bus.out_valid;
        d   = bus.diff;
        br  = bus.borrow;
        ov  = bus.ovf;
        zr  = bus.zero;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if ({bus.diff, bus.borrow, bus.ovf, bus.zero} !== 35'd0) begin n_fail++;
            $display("FAIL reset_outputs: got diff=%h b=%b o=%b z=%b want all 0", bus.diff, bus.borrow, bus.ovf, bus.zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic e, v, br, ov, zr;
        logic [31:0] d;
        run_one(32'h0000_0005, 32'h0000_0003, e, v, d, br, ov, zr);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: out_valid got %b want 0", e); end
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", v); end
        n_checks++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL basic_diff: got %h want 00000002", d); end
        n_checks++; if ({br, ov, zr} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got b/o/z=%b%b%b want 000", br, ov, zr); end
    endtask

    task automatic test_borrow();
        logic e, v, br, ov, zr;
        logic [31:0] d;
        run_one(32'h0000_0003, 32'h0000_0005, e, v, d, br, ov, zr);
        n_checks++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL borrow_diff: got %h want fffffffe", d); end
        n_checks++; if (br !== 1'b1) begin n_fail++; $display("FAIL borrow_flag: got %b want 1", br); end
        n_checks++; if ({ov, zr} !== 2'b00) begin n_fail++; $display("FAIL borrow_ovf_zero: got %b%b want 00", ov, zr); end
    endtask

    task automatic test_flags();
        logic e, v, br, ov, zr;
        logic [31:0] d;
        run_one(32'h8000_0000, 32'h0000_0001, e, v, d, br, ov, zr);
        n_checks++; if (d !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ovf_diff: got %h want 7fffffff", d); end
        n_checks++; if (ov !== FLAGS) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", ov, FLAGS); end
        n_checks++; if (br !== 1'b0) begin n_fail++; $display("FAIL ovf_borrow: got %b want 0", br); end
        run_one(32'h1234_5678, 32'h1234_5678, e, v, d, br, ov, zr);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL zero_diff: got %h want 00000000", d); end
        n_checks++; if (zr !== FLAGS) begin n_fail++; $display("FAIL zero_flag: got %b want %b", zr, FLAGS); end
        n_checks++; if ({br, ov} !== 2'b00) begin n_fail++; $display("FAIL zero_borrow_ovf: got %b%b want 00", br, ov); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic [31:0] ed [3];
        logic        eb [3];
        logic        eo [3];
        av = '{32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_FFFF};
        bv = '{32'h0000_0001, 32'h0000_FFFF, 32'hFFFF_FFFF};
        ed = '{32'h0000_FFFF, 32'hFFFE_0001, 32'h8000_0000};
        eb = '{1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, FLAGS};
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = av[0];
        bus.b = bv[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i + 1 < 3) begin bus.a = av[i+1]; bus.b = bv[i+1]; end
            else bus.in_valid = 1'b0;
            if (i >= 1 && i <= 3) begin
                n_checks++; if (bus.out_valid !== 1'b1 || bus.diff !== ed[i-1] || bus.borrow !== eb[i-1] || bus.ovf !== eo[i-1]) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got v=%b diff=%h b=%b o=%b want v=1 diff=%h b=%b o=%b",
                             i - 1, bus.out_valid, bus.diff, bus.borrow, bus.ovf, ed[i-1], eb[i-1], eo[i-1]);
                end
            end
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [31:0] ed [4];
        logic [31:0] got [4];
        int sent, ng;
        av = '{32'd10, 32'd100, 32'd0, 32'hFFFF_FFFF};
        bv = '{32'd1,  32'd50,  32'd1, 32'hFFFF_FFFE};
        ed = '{32'd9,  32'd50,  32'hFFFF_FFFF, 32'd1};
        sent = 0;
        ng   = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = av[0];
        bus.b = bv[0];
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc <= 6) begin
                n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.diff !== ed[0]) begin
                    n_fail++;
                    $display("FAIL stall_c%0d: got in_ready=%b out_valid=%b diff=%h want 0/1/%h",
                             cyc, bus.in_ready, bus.out_valid, bus.diff, ed[0]);
                end
            end
            if (cyc == 6) begin
                n_checks++; if (sent !== 2) begin n_fail++; $display("FAIL stall_accepted: got %0d want 2", sent); end
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                if (ng < 4) got[ng] = bus.diff;
                ng++;
            end
            @(posedge clk); #1;
            if (sent < 4) begin bus.a = av[sent]; bus.b = bv[sent]; end
            else bus.in_valid = 1'b0;
            if (cyc == 6) bus.out_ready = 1'b1;
        end
        n_checks++; if (ng !== 4) begin n_fail++; $display("FAIL bp_count: got %0d results want 4", ng); end
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                n_checks++; if (got[i] !== ed[i]) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], ed[i]); end
            end
        end
    endtask

    task automatic test_midflight_reset();
        logic e, v, br, ov, zr;
        logic [31:0] d;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 32'd20; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.a = 32'd30; bus.b = 32'd4;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL mr_full: got out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 32'h0) begin n_fail++;
            $display("FAIL mr_flush: got out_valid=%b in_ready=%b diff=%h want 0/1/0", bus.out_valid, bus.in_ready, bus.diff); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(32'd7, 32'd2, e, v, d, br, ov, zr);
        n_checks++; if (e !== 1'b0 || v !== 1'b1 || d !== 32'd5 || br !== 1'b0) begin n_fail++;
            $display("FAIL mr_after: got early=%b v=%b diff=%h b=%b want 0/1/00000005/0", e, v, d, br); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_flags();
        test_back_to_back();
        test_backpressure();
        test_midflight_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
